// File: rtl/ip_codma_bus_arbiter_if.sv
// Requester-side and memory-bus signal bundle for the codma bus arbiter.
// The arbiter takes the master view; requesters/memory model take the slave view.
interface ip_codma_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 4
);
  logic [NUM_REQ-1:0]        req_rd_i;
  logic [NUM_REQ-1:0]        req_wr_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*SIZE_W-1:0] req_size_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        req_done_i;
  logic                      error_i;
  logic                      bus_grant_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      bus_read_o;
  logic                      bus_write_o;
  logic                      bus_write_valid_o;
  logic [ADDR_W-1:0]         bus_addr_o;
  logic [SIZE_W-1:0]         bus_size_o;
  logic [DATA_W-1:0]         bus_write_data_o;
  logic                      busy_o;
  logic                      timeout_o;

  modport master (
    input  req_rd_i, req_wr_i, req_addr_i, req_size_i, req_wdata_i, req_done_i,
           error_i, bus_grant_i,
    output grant_o, bus_read_o, bus_write_o, bus_write_valid_o, bus_addr_o,
           bus_size_o, bus_write_data_o, busy_o, timeout_o
  );

  modport slave (
    output req_rd_i, req_wr_i, req_addr_i, req_size_i, req_wdata_i, req_done_i,
           error_i, bus_grant_i,
    input  grant_o, bus_read_o, bus_write_o, bus_write_valid_o, bus_addr_o,
           bus_size_o, bus_write_data_o, busy_o, timeout_o
  );
endinterface

// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin N-requester arbiter and sole registered driver of the codma memory bus.
// Optional ask-phase watchdog enabled by defining CODMA_ARB_TIMEOUT_EN.

// Per-channel request qualification against the current owner.
module ip_codma_bus_arbiter_lane (
  input  logic rd,
  input  logic wr,
  input  logic done,
  input  logic is_owner,
  input  logic op_wr,
  output logic active,
  output logic own_req,
  output logic own_done
);
  assign active   = rd | wr;
  assign own_req  = is_owner & (op_wr ? wr : rd);
  assign own_done = is_owner & done;
endmodule

module ip_codma_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int SIZE_W         = 4,
  parameter int IDLE_SIZE      = 9,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  ip_codma_bus_arbiter_if.master bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]  NREQ     = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ - 1);
  localparam logic [SIZE_W-1:0] IDLE_SZ = SIZE_W'(IDLE_SIZE);

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ASK     = 3'd1,
    ARB_XFER    = 3'd2,
    ARB_RELEASE = 3'd3
  } arb_state_e;

  arb_state_e state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, owner_q, owner_d, sel_idx;
  logic             op_wr_q, op_wr_d, sel_found;
  logic             error_q, err_rise, ask_limit, timeout_d;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][SIZE_W-1:0] size_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_REQ-1:0] owner_oh, active_v, own_req_v, own_done_v;
  logic               own_req, own_done;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               rd_q, rd_d, wr_q, wr_d, wv_q, wv_d, busy_q, timeout_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [DATA_W-1:0]  data_q, data_d;

  assign addr_a  = bus.req_addr_i;
  assign size_a  = bus.req_size_i;
  assign wdata_a = bus.req_wdata_i;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    ip_codma_bus_arbiter_lane u_lane (
      .rd       (bus.req_rd_i[k]),
      .wr       (bus.req_wr_i[k]),
      .done     (bus.req_done_i[k]),
      .is_owner (owner_oh[k]),
      .op_wr    (op_wr_q),
      .active   (active_v[k]),
      .own_req  (own_req_v[k]),
      .own_done (own_done_v[k])
    );
  end

  // Non-owner req_done is dropped here by the lane owner qualification.
  assign own_req  = |own_req_v;
  assign own_done = |own_done_v;
  assign err_rise = bus.error_i & ~error_q;

  // Rotating search: first active channel at or after the pointer.
  always_comb begin
    logic [PTR_W:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + i[PTR_W:0];
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && active_v[idx[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = idx[PTR_W-1:0];
      end
    end
  end

`ifdef CODMA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] ask_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                 ask_cnt_q <= '0;
    else if (state_q != ARB_ASK)    ask_cnt_q <= '0;
    else if (ask_cnt_q != CNT_LIM)  ask_cnt_q <= ask_cnt_q + 1'b1;
  end

  assign ask_limit = (state_q == ARB_ASK) && (ask_cnt_q == CNT_LIM);
`else
  assign ask_limit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_wr_d   = op_wr_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          op_wr_d = ~bus.req_rd_i[sel_idx];
          state_d = ARB_ASK;
        end
      end
      ARB_ASK: begin
        // A grant arriving on the watchdog limit cycle still wins.
        if (bus.bus_grant_i)   state_d = ARB_XFER;
        else if (!own_req)     state_d = ARB_RELEASE;
        else if (ask_limit) begin
          state_d   = ARB_RELEASE;
          timeout_d = 1'b1;
        end
      end
      ARB_XFER: begin
        if (own_done) state_d = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        ptr_d   = (owner_q == LAST) ? '0 : owner_q + 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (err_rise) begin
      state_d   = ARB_IDLE;
      timeout_d = 1'b0;
    end
  end

  // Bus outputs are registered from the next state so a strobe follows its request by one cycle.
  always_comb begin
    grant_d = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wv_d    = 1'b0;
    addr_d  = addr_q;
    size_d  = IDLE_SZ;
    data_d  = data_q;
    if (err_rise) begin
      size_d = size_q;
    end else begin
      case (state_d)
        ARB_ASK: begin
          grant_d[owner_d] = 1'b1;
          rd_d   = ~op_wr_d;
          wr_d   = op_wr_d;
          addr_d = addr_a[owner_d];
          size_d = size_a[owner_d];
        end
        ARB_XFER: begin
          grant_d[owner_d] = 1'b1;
          wv_d   = op_wr_d;
          addr_d = addr_a[owner_d];
          size_d = size_a[owner_d];
          if (op_wr_d) data_d = wdata_a[owner_d];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      op_wr_q   <= 1'b0;
      error_q   <= 1'b0;
      grant_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wv_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= IDLE_SZ;
      data_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      op_wr_q   <= op_wr_d;
      error_q   <= bus.error_i;
      grant_q   <= grant_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wv_q      <= wv_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      data_q    <= data_d;
      busy_q    <= (state_d != ARB_IDLE);
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant_o           = grant_q;
  assign bus.bus_read_o        = rd_q;
  assign bus.bus_write_o       = wr_q;
  assign bus.bus_write_valid_o = wv_q;
  assign bus.bus_addr_o        = addr_q;
  assign bus.bus_size_o        = size_q;
  assign bus.bus_write_data_o  = data_q;
  assign bus.busy_o            = busy_q;
  assign bus.timeout_o         = timeout_q;

  a_cfg_legal: assert property (@(posedge clk_i)
    (NUM_REQ >= 1) && (NUM_REQ <= 8) && (TIMEOUT_CYCLES >= 1));
  a_state_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    state_q inside {ARB_IDLE, ARB_ASK, ARB_XFER, ARB_RELEASE});
  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(grant_q));
endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// Directed bench for ip_codma_bus_arbiter: reset, single read, round robin,
// rd/wr conflict, error abort, ask watchdog (either build), async reset.
module tb_ip_codma_bus_arbiter;
  localparam int NUM_REQ = 2, ADDR_W = 32, DATA_W = 64, SIZE_W = 4;
  localparam int IDLE_SIZE = 9, TIMEOUT_CYCLES = 8;
`ifdef CODMA_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  int total = 0;
  int bad = 0;

  ip_codma_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                            .SIZE_W(SIZE_W)) bus ();

  ip_codma_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .SIZE_W(SIZE_W), .IDLE_SIZE(IDLE_SIZE),
                         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_rd_i    = '0;
    bus.req_wr_i    = '0;
    bus.req_addr_i  = '0;
    bus.req_size_i  = '0;
    bus.req_wdata_i = '0;
    bus.req_done_i  = '0;
    bus.error_i     = 1'b0;
    bus.bus_grant_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    #3;
    reset_n_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n_i = 1'b0;
    #12;
    total++;
    if ({bus.grant_o, bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o, bus.busy_o, bus.timeout_o} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000000", {bus.grant_o, bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o, bus.busy_o, bus.timeout_o});
    end
    total++;
    if (bus.bus_size_o !== 4'd9) begin bad++; $display("FAIL reset_size got=%0d exp=9", bus.bus_size_o); end
    total++;
    if ({bus.bus_addr_o, bus.bus_write_data_o} !== 96'h0) begin bad++; $display("FAIL reset_addr_data got=%h exp=0", {bus.bus_addr_o, bus.bus_write_data_o}); end
    reset_n_i = 1'b1;
    step();
    total++;
    if ({bus.busy_o, bus.bus_size_o} !== {1'b0, 4'd9}) begin bad++; $display("FAIL idle_after_reset got=%h exp=09", {bus.busy_o, bus.bus_size_o}); end
  endtask

  task automatic test_single_read();
    logic       exp_rd, exp_busy;
    logic [1:0] exp_gnt;
    logic [3:0] exp_size;
    do_reset();
    bus.req_rd_i[0] = 1'b1;
    bus.req_addr_i[0 +: 32] = 32'h1000;
    bus.req_size_i[0 +: 4] = 4'd3;
    for (int c = 1; c <= 9; c++) begin
      step();
      exp_rd   = (c <= 3);
      exp_gnt  = (c <= 7) ? 2'b01 : 2'b00;
      exp_size = (c <= 7) ? 4'd3 : 4'd9;
      exp_busy = (c <= 8);
      total++;
      if ({bus.bus_read_o, bus.bus_write_o, bus.grant_o, bus.bus_size_o, bus.busy_o} !== {exp_rd, 1'b0, exp_gnt, exp_size, exp_busy}) begin
        bad++; $display("FAIL single_read cyc=%0d got rd=%b wr=%b gnt=%b size=%0d busy=%b exp rd=%b wr=0 gnt=%b size=%0d busy=%b",
                        c, bus.bus_read_o, bus.bus_write_o, bus.grant_o, bus.bus_size_o, bus.busy_o, exp_rd, exp_gnt, exp_size, exp_busy);
      end
      if (c == 1) begin
        total++;
        if (bus.bus_addr_o !== 32'h1000) begin bad++; $display("FAIL single_read_addr got=%h exp=1000", bus.bus_addr_o); end
      end
      case (c)
        3: bus.bus_grant_i = 1'b1;
        4: begin bus.bus_grant_i = 1'b0; bus.req_done_i[1] = 1'b1; end
        5: bus.req_done_i[1] = 1'b0;
        7: bus.req_done_i[0] = 1'b1;
        8: begin bus.req_done_i[0] = 1'b0; bus.req_rd_i[0] = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  seq [3];
    int          nseq, xcnt;
    logic        prev_wr;
    logic [63:0] wd0, wd1, exp_d;
    do_reset();
    wd0 = 64'h0000_00A0_0000_00A1;
    wd1 = 64'h0000_00B0_0000_00B1;
    bus.req_wr_i = 2'b11;
    bus.req_addr_i = {32'h200, 32'h100};
    bus.req_size_i = {4'd2, 4'd2};
    bus.req_wdata_i = {wd1, wd0};
    nseq = 0; xcnt = 0; prev_wr = 1'b0;
    for (int c = 0; c < 40 && nseq < 3; c++) begin
      step();
      if (bus.bus_write_o && !prev_wr) begin seq[nseq] = bus.grant_o; nseq++; end
      prev_wr = bus.bus_write_o;
      if (bus.bus_write_valid_o) begin
        exp_d = bus.grant_o[1] ? wd1 : wd0;
        total++;
        if (bus.bus_write_data_o !== exp_d) begin
          bad++; $display("FAIL rr_wdata gnt=%b got=%h exp=%h", bus.grant_o, bus.bus_write_data_o, exp_d);
        end
        xcnt++;
        if (xcnt == 1) begin
          if (bus.grant_o[1]) wd1 = wd1 + 64'h10;
          else                wd0 = wd0 + 64'h10;
        end
        bus.req_done_i = (xcnt == 2) ? bus.grant_o : 2'b00;
      end else begin
        xcnt = 0;
        bus.req_done_i = '0;
      end
      bus.req_wdata_i = {wd1, wd0};
      bus.bus_grant_i = bus.bus_write_o;
    end
    total++;
    if (nseq != 3) begin bad++; $display("FAIL rr_count got=%0d exp=3", nseq); end
    total++;
    if ({seq[0], seq[1], seq[2]} !== 6'b01_10_01) begin
      bad++; $display("FAIL rr_order got=%b %b %b exp=01 10 01", seq[0], seq[1], seq[2]);
    end
    clear_inputs();
    step(); step(); step();
  endtask

  task automatic test_conflict();
    logic [1:0] ops [2];
    logic [1:0] gnts [2];
    int         nops;
    logic       last_rd;
    do_reset();
    bus.req_rd_i[1] = 1'b1;
    bus.req_wr_i[1] = 1'b1;
    bus.req_addr_i[32 +: 32] = 32'h300;
    bus.req_size_i[4 +: 4] = 4'd1;
    nops = 0; last_rd = 1'b0;
    for (int c = 0; c < 30 && nops < 2; c++) begin
      step();
      bus.req_done_i = '0;
      if (bus.bus_read_o || bus.bus_write_o) begin
        ops[nops] = {bus.bus_read_o, bus.bus_write_o};
        gnts[nops] = bus.grant_o;
        nops++;
        last_rd = bus.bus_read_o;
      end else if (bus.grant_o != 2'b00) begin
        bus.req_done_i = bus.grant_o;
        if (last_rd) bus.req_rd_i[1] = 1'b0;
        else         bus.req_wr_i[1] = 1'b0;
      end
      bus.bus_grant_i = bus.bus_read_o | bus.bus_write_o;
    end
    total++;
    if (nops != 2) begin bad++; $display("FAIL conflict_count got=%0d exp=2", nops); end
    total++;
    if ({ops[0], ops[1]} !== 4'b10_01) begin bad++; $display("FAIL conflict_order got=%b %b exp=10 01 (rd,wr)", ops[0], ops[1]); end
    total++;
    if ({gnts[0], gnts[1]} !== 4'b10_10) begin bad++; $display("FAIL conflict_grant got=%b %b exp=10 10", gnts[0], gnts[1]); end
    clear_inputs();
    step(); step(); step();
  endtask

  task automatic test_error();
    do_reset();
    bus.req_wr_i[0] = 1'b1;
    bus.req_addr_i[0 +: 32] = 32'h500;
    bus.req_size_i[0 +: 4] = 4'd2;
    bus.req_wdata_i[0 +: 64] = 64'hDEAD_0000_BEEF_0001;
    step();
    total++;
    if ({bus.bus_write_o, bus.grant_o} !== 3'b1_01) begin bad++; $display("FAIL err_pre_ask got=%b exp=101", {bus.bus_write_o, bus.grant_o}); end
    bus.bus_grant_i = 1'b1;
    step();
    total++;
    if ({bus.bus_write_valid_o, bus.bus_write_data_o} !== {1'b1, 64'hDEAD_0000_BEEF_0001}) begin
      bad++; $display("FAIL err_pre_xfer got=%b %h exp=1 dead0000beef0001", bus.bus_write_valid_o, bus.bus_write_data_o);
    end
    bus.bus_grant_i = 1'b0;
    bus.error_i = 1'b1;
    bus.req_wr_i = 2'b10;
    bus.req_addr_i[32 +: 32] = 32'h2000;
    bus.req_size_i[4 +: 4] = 4'd5;
    bus.req_wdata_i[64 +: 64] = 64'h1234_5678_9ABC_DEF0;
    step();
    total++;
    if ({bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o, bus.grant_o} !== 5'b0) begin
      bad++; $display("FAIL err_blank got=%b exp=00000", {bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o, bus.grant_o});
    end
    total++;
    if ({bus.bus_addr_o, bus.bus_size_o, bus.bus_write_data_o} !== {32'h500, 4'd2, 64'hDEAD_0000_BEEF_0001}) begin
      bad++; $display("FAIL err_hold got=%h %0d %h exp=500 2 dead0000beef0001", bus.bus_addr_o, bus.bus_size_o, bus.bus_write_data_o);
    end
    step();
    total++;
    if ({bus.bus_write_o, bus.grant_o, bus.bus_addr_o, bus.bus_size_o} !== {1'b1, 2'b10, 32'h2000, 4'd5}) begin
      bad++; $display("FAIL err_resume_ask got=%b %b %h %0d exp=1 10 2000 5", bus.bus_write_o, bus.grant_o, bus.bus_addr_o, bus.bus_size_o);
    end
    bus.bus_grant_i = 1'b1;
    step();
    total++;
    if ({bus.bus_write_valid_o, bus.grant_o, bus.bus_write_data_o} !== {1'b1, 2'b10, 64'h1234_5678_9ABC_DEF0}) begin
      bad++; $display("FAIL err_resume_xfer got=%b %b %h exp=1 10 123456789abcdef0", bus.bus_write_valid_o, bus.grant_o, bus.bus_write_data_o);
    end
    bus.bus_grant_i = 1'b0;
    bus.req_done_i = 2'b10;
    step();
    total++;
    if ({bus.grant_o, bus.bus_size_o, bus.busy_o} !== {2'b00, 4'd9, 1'b1}) begin
      bad++; $display("FAIL err_resume_release got=%b %0d %b exp=00 9 1", bus.grant_o, bus.bus_size_o, bus.busy_o);
    end
    clear_inputs();
    step(); step();
  endtask

  task automatic test_timeout();
    logic       exp_rd, exp_to;
    logic [1:0] exp_gnt;
    do_reset();
    bus.req_rd_i = 2'b11;
    bus.req_addr_i = {32'h4400, 32'h4000};
    bus.req_size_i = {4'd1, 4'd1};
    for (int c = 1; c <= 15; c++) begin
      step();
      if (TMO) begin
        exp_rd  = (c <= 8) || (c >= 11);
        exp_gnt = (c <= 8) ? 2'b01 : ((c >= 11) ? 2'b10 : 2'b00);
        exp_to  = (c == 9);
      end else begin
        exp_rd  = (c <= 12) || (c == 15);
        exp_gnt = (c <= 12) ? 2'b01 : ((c == 15) ? 2'b10 : 2'b00);
        exp_to  = 1'b0;
      end
      total++;
      if ({bus.bus_read_o, bus.grant_o, bus.timeout_o} !== {exp_rd, exp_gnt, exp_to}) begin
        bad++; $display("FAIL timeout cyc=%0d got rd=%b gnt=%b to=%b exp rd=%b gnt=%b to=%b",
                        c, bus.bus_read_o, bus.grant_o, bus.timeout_o, exp_rd, exp_gnt, exp_to);
      end
      if (c == 12) bus.req_rd_i[0] = 1'b0;
    end
    clear_inputs();
    do_reset();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_wr_i[0] = 1'b1;
    bus.req_addr_i[0 +: 32] = 32'h700;
    bus.req_size_i[0 +: 4] = 4'd6;
    bus.req_wdata_i[0 +: 64] = 64'h55;
    step();
    bus.bus_grant_i = 1'b1;
    step();
    total++;
    if ({bus.bus_write_valid_o, bus.grant_o} !== 3'b1_01) begin bad++; $display("FAIL areset_pre got=%b exp=101", {bus.bus_write_valid_o, bus.grant_o}); end
    #2;
    reset_n_i = 1'b0;
    #1;
    total++;
    if ({bus.grant_o, bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o, bus.busy_o, bus.timeout_o} !== 7'b0) begin
      bad++; $display("FAIL areset_ctrl got=%b exp=0000000", {bus.grant_o, bus.bus_read_o, bus.bus_write_o, bus.bus_write_valid_o, bus.busy_o, bus.timeout_o});
    end
    total++;
    if ({bus.bus_addr_o, bus.bus_size_o, bus.bus_write_data_o} !== {32'h0, 4'd9, 64'h0}) begin
      bad++; $display("FAIL areset_bus got=%h %0d %h exp=0 9 0", bus.bus_addr_o, bus.bus_size_o, bus.bus_write_data_o);
    end
    clear_inputs();
    #4;
    reset_n_i = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_conflict();
    test_error();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ip_codma_bus_arbiter.md
Name: ip_codma_bus_arbiter

Overview:
- Parametrised N-requester bus arbiter and output driver for the codma memory bus.
- Sits between the read, write, status and future extra channel machines and `mem_interface.master`.
- It is the only driver of the bus signals.
- Round-robin arbitration, fully registered bus outputs, error blanking, optional grant timeout.

Parameters:
- NUM_REQ, 2: number of requester channels, min 1, max 8.
- ADDR_W, 32: bus address width.
- DATA_W, 64: bus write-data width (two 32-bit words per beat).
- SIZE_W, 4: transfer size field width.
- IDLE_SIZE, 9: value driven on bus_size_o when the bus is idle.
- TIMEOUT_CYCLES, 64: ask-phase watchdog limit. Used only with CODMA_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_rd_i  in  NUM_REQ  per-channel read request.
- req_wr_i  in  NUM_REQ  per-channel write request.
- req_addr_i  in  NUM_REQ*ADDR_W  per-channel address, channel k at [k*ADDR_W +: ADDR_W].
- req_size_i  in  NUM_REQ*SIZE_W  per-channel size.
- req_wdata_i  in  NUM_REQ*DATA_W  per-channel write beat.
- req_done_i  in  NUM_REQ  granted channel releases the bus.
- error_i  in  1  main-machine error state.
- bus_grant_i  in  1  memory accepts the pending read/write strobe.
- grant_o  out  NUM_REQ  one-hot owner of the bus.
- bus_read_o  out  1  read strobe.
- bus_write_o  out  1  write strobe.
- bus_write_valid_o  out  1  write data valid.
- bus_addr_o  out  ADDR_W  address.
- bus_size_o  out  SIZE_W  size.
- bus_write_data_o  out  DATA_W  write beat.
- busy_o  out  1  FSM not in ARB_IDLE.
- timeout_o  out  1  one-cycle watchdog pulse.

Behaviour:
- **Reset values:** every output is 0, except bus_size_o = IDLE_SIZE. State is ARB_IDLE and the round-robin pointer is 0.
- **Output registering:** all bus outputs and grant_o are registered. A request sampled on cycle N produces a strobe on cycle N+1.
- **ARB_IDLE:**
  - Active channels are those with req_rd_i | req_wr_i set.
  - Select the first active channel at or after the pointer, wrapping modulo NUM_REQ.
  - Latch the owner index and the op: read wins if both rd and wr are set on the same channel.
  - Go to ARB_ASK. No active channel: stay in ARB_IDLE.
- **ARB_ASK:**
  - Drive bus_read_o or bus_write_o = 1, plus the owner's addr and size.
  - bus_grant_i = 1: drop the strobe and go to ARB_XFER.
  - Owner drops its request before grant: go to ARB_RELEASE.
- **ARB_XFER:**
  - Drive the owner's addr and size.
  - For writes, also drive bus_write_valid_o = 1 and bus_write_data_o = owner wdata, tracking owner changes each cycle.
  - Owner's req_done_i = 1: go to ARB_RELEASE.
- **ARB_RELEASE:**
  - One bubble cycle: strobes 0, bus_size_o = IDLE_SIZE, grant_o = 0.
  - Pointer = owner + 1 mod NUM_REQ.
  - Go to ARB_IDLE.
- **grant_o:** one-hot of the owner in ARB_ASK and ARB_XFER, otherwise 0. Never more than one bit set.
- **Error handling:**
  - Rising edge of error_i (error_i = 1 and its registered copy = 0) forces next state ARB_IDLE.
  - On that edge, all strobes, write_valid and grant_o are 0 on the next cycle. Addr, size and data hold.
  - While error_i stays high, arbitration resumes normally, so the status write can proceed.
- **Masking:** req_done_i from non-owners is ignored.
- **Mid-operation reset:** all outputs return to reset values immediately (asynchronous).
- **Illegal state:** an unused encoding returns to ARB_IDLE with idle outputs. The covering assertion is never expected to fire.
- **NUM_REQ = 1:** the pointer is constant 0.

Optional Feature:
- Macro: CODMA_ARB_TIMEOUT_EN.
- **Defined:**
  - An ask-cycle counter clears on entry to ARB_ASK.
  - If the counter reaches TIMEOUT_CYCLES without bus_grant_i, timeout_o pulses 1 for one cycle and the FSM goes to ARB_RELEASE, so the pointer advances.
  - A grant on the same cycle as the limit wins; no timeout is raised.
- **Undefined:** ARB_ASK waits indefinitely and timeout_o is tied 0.

Test Plan:
- **Single read:** ch0 read with addr 0x1000, size 3; grant after 2 cycles; done 4 cycles later.
  - Required: bus_read_o high exactly 3 cycles starting one cycle after the request, addr 0x1000.
  - Required: grant_o = 01 until done; then 1 bubble cycle with size 9.
- **Round robin:** ch0 and ch1 both request writes continuously.
  - Required: grants alternate 01, 10, 01.
  - Required: bus_write_data_o equals the owner's wdata while write_valid is high.
- **Same-channel conflict:** ch1 sets rd and wr on the same cycle.
  - Required: read issued first; write issued after release and re-arbitration.
- **Error abort:** error_i rises during ch0 ARB_XFER.
  - Required: next cycle has strobes, write_valid and grant_o all 0.
  - Required: with error_i still high, a ch1 write to 0x2000 completes normally.
- **Timeout (macro on, TIMEOUT_CYCLES = 8):** bus_grant_i never asserted.
  - Required: timeout_o pulses once after 8 ask cycles; ch1 is served next.
- **Async reset:** reset_n_i low mid-XFER.
  - Required: outputs clear without a clock edge; bus_size_o = 9.
